// File: rtl/sign_extended_pkg.sv
// Shared definitions for the decode-stage immediate extension unit.
// Holds the extension-mode encodings and the default datapath widths.
// Imported by imm_ext_core and sign_extended.
package sign_extended_pkg;

    localparam int IMM_WIDTH  = 16;
    localparam int WORD_WIDTH = 32;

    // Extension modes for the registered path (ext_mode input).
    typedef enum logic [1:0] {
        EXT_SIGN   = 2'b00,   // sign extension
        EXT_ZERO   = 2'b01,   // zero extension
        EXT_UPPER  = 2'b10,   // immediate in the upper half (LUI)
        EXT_BRANCH = 2'b11    // sign extension shifted left by 2
    } ext_mode_e;

endpackage

// File: rtl/sign_extended_imm_ext_core.sv
// Purpose : mode-selected widening of an immediate to OUT_WIDTH bits.
// Latency : purely combinational, zero cycles.
// Backpr. : none; no handshake, output follows inputs.
// Ports   : imm_in (IN_WIDTH raw immediate), mode (2-bit ext mode),
//           ext_out (OUT_WIDTH result). OUT_WIDTH must exceed IN_WIDTH + 2.
module imm_ext_core
    import sign_extended_pkg::*;
#(
    parameter int IN_WIDTH  = IMM_WIDTH,
    parameter int OUT_WIDTH = WORD_WIDTH
) (
    input  logic [IN_WIDTH-1:0]  imm_in,
    input  logic [1:0]           mode,
    output logic [OUT_WIDTH-1:0] ext_out
);

    localparam int PAD = OUT_WIDTH - IN_WIDTH;

    logic [OUT_WIDTH-1:0] sext;

    assign sext = {{PAD{imm_in[IN_WIDTH-1]}}, imm_in};

    always_comb begin
        ext_out = sext;
        case (ext_mode_e'(mode))
            EXT_SIGN:   ext_out = sext;
            EXT_ZERO:   ext_out = {{PAD{1'b0}}, imm_in};
            EXT_UPPER:  ext_out = {imm_in, {PAD{1'b0}}};
            // Word offset: the two bits shifted out of the top are dropped.
            EXT_BRANCH: ext_out = {sext[OUT_WIDTH-3:0], 2'b00};
            default:    ext_out = sext;
        endcase
    end

endmodule

// File: rtl/sign_extended.sv
// Purpose : decode-stage immediate extension; combinational sign-extend plus
//           a registered, mode-selected copy with neg/zero flags for ID/EX.
// Latency : data_out 0 cycles; ext_q/ext_valid/ext_neg/ext_zero 1 cycle.
// Backpr. : stall freezes every registered output; no ready is returned.
// Ports   : clk, rst (sync active-high), sign_extend_in, data_out,
//           ext_mode, in_valid, stall, ext_q, ext_valid, ext_neg, ext_zero.
module sign_extended
    import sign_extended_pkg::*;
#(
    parameter int IN_WIDTH  = IMM_WIDTH,
    parameter int OUT_WIDTH = WORD_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  sign_extend_in,
    output logic [OUT_WIDTH-1:0] data_out,
    input  logic [1:0]           ext_mode,
    input  logic                 in_valid,
    input  logic                 stall,
    output logic [OUT_WIDTH-1:0] ext_q,
    output logic                 ext_valid,
    output logic                 ext_neg,
    output logic                 ext_zero
);

    // Same-cycle path: depends on sign_extend_in only, so it stays correct
    // even while the control inputs are undriven.
    assign data_out = {{(OUT_WIDTH-IN_WIDTH){sign_extend_in[IN_WIDTH-1]}}, sign_extend_in};

    logic [OUT_WIDTH-1:0] ext_f;

    imm_ext_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_imm_ext_core (
        .imm_in  (sign_extend_in),
        .mode    (ext_mode),
        .ext_out (ext_f)
    );

    logic [OUT_WIDTH-1:0] ext_d;
    logic                 ext_valid_d, ext_valid_q;
    logic                 ext_neg_d,   ext_neg_q;
    logic                 ext_zero_d,  ext_zero_q;

    always_comb begin
        ext_d       = ext_q;
        ext_valid_d = ext_valid_q;
        ext_neg_d   = ext_neg_q;
        ext_zero_d  = ext_zero_q;
        if (!stall) begin
            if (in_valid) begin
                ext_d       = ext_f;
                ext_valid_d = 1'b1;
                ext_neg_d   = ext_f[OUT_WIDTH-1];
                ext_zero_d  = (ext_f == '0);
            end else begin
                // Data and flags keep the last capture; only valid drops.
                ext_valid_d = 1'b0;
            end
        end
    end

    // Reset wins over stall and in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q       <= '0;
            ext_valid_q <= 1'b0;
            ext_neg_q   <= 1'b0;
            ext_zero_q  <= 1'b1;
        end else begin
            ext_q       <= ext_d;
            ext_valid_q <= ext_valid_d;
            ext_neg_q   <= ext_neg_d;
            ext_zero_q  <= ext_zero_d;
        end
    end

    assign ext_valid = ext_valid_q;
    assign ext_neg   = ext_neg_q;
    assign ext_zero  = ext_zero_q;

endmodule

// File: tb/tb_sign_extended.sv
// Directed bench for sign_extended: combinational path, reset, all modes,
// boundary immediates, stall hold, valid drop, zero flag, mid-stream reset.
module tb_sign_extended;

    logic        clk;
    logic        rst;
    logic [15:0] sign_extend_in;
    logic [31:0] data_out;
    logic [1:0]  ext_mode;
    logic        in_valid;
    logic        stall;
    logic [31:0] ext_q;
    logic        ext_valid;
    logic        ext_neg;
    logic        ext_zero;

    int n_cmp = 0;
    int n_bad = 0;

    sign_extended dut (
        .clk            (clk),
        .rst            (rst),
        .sign_extend_in (sign_extend_in),
        .data_out       (data_out),
        .ext_mode       (ext_mode),
        .in_valid       (in_valid),
        .stall          (stall),
        .ext_q          (ext_q),
        .ext_valid      (ext_valid),
        .ext_neg        (ext_neg),
        .ext_zero       (ext_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] comb_in  [5] = '{16'h0000, 16'h0001, 16'h8000, 16'h7FFF, 16'hFFFF};
    logic [31:0] comb_exp [5] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_8000,
                                  32'h0000_7FFF, 32'hFFFF_FFFF};
    logic [31:0] mode_exp [4] = '{32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000, 32'hFFFE_0004};
    logic        mode_neg [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        // Combinational path with rst/ext_mode/in_valid/stall left undriven.
        for (int i = 0; i < 5; i++) begin
            sign_extend_in = comb_in[i];
            #1;
            check($sformatf("comb_%0d", i), data_out, comb_exp[i]);
        end

        // Reset held for two edges with in_valid high.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; stall = 1'b0; ext_mode = 2'b00;
        sign_extend_in = 16'h5555;
        tick();
        tick();
        check("rst_ext_q",     ext_q,             32'h0);
        check("rst_valid",     {31'b0, ext_valid}, 32'h0);
        check("rst_zero",      {31'b0, ext_zero},  32'h1);
        check("rst_neg",       {31'b0, ext_neg},   32'h0);
        check("rst_data_out",  data_out,          32'h0000_5555);

        // Every mode on 0x8001.
        rst = 1'b0;
        sign_extend_in = 16'h8001;
        for (int m = 0; m < 4; m++) begin
            ext_mode = 2'(m);
            tick();
            check($sformatf("mode%0d_q", m),   ext_q,             mode_exp[m]);
            check($sformatf("mode%0d_neg", m), {31'b0, ext_neg},   {31'b0, mode_neg[m]});
            check($sformatf("mode%0d_vld", m), {31'b0, ext_valid}, 32'h1);
        end

        // Boundary immediates.
        sign_extend_in = 16'h8000; ext_mode = 2'b11; tick();
        check("bnd_8000_br", ext_q, 32'hFFFE_0000);
        sign_extend_in = 16'hFFFF; ext_mode = 2'b11; tick();
        check("bnd_ffff_br", ext_q, 32'hFFFF_FFFC);
        sign_extend_in = 16'h7FFF; ext_mode = 2'b00; tick();
        check("bnd_7fff_sx", ext_q, 32'h0000_7FFF);
        check("bnd_7fff_neg", {31'b0, ext_neg}, 32'h0);

        // Stall holds the captured value for three edges.
        sign_extend_in = 16'h1234; ext_mode = 2'b00; tick();
        check("stall_cap", ext_q, 32'h0000_1234);
        stall = 1'b1; sign_extend_in = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall_q_%0d", k),   ext_q,             32'h0000_1234);
            check($sformatf("stall_vld_%0d", k), {31'b0, ext_valid}, 32'h1);
        end
        check("stall_data_out", data_out, 32'hFFFF_FFFF);

        // Valid drop keeps data and flags.
        stall = 1'b0; in_valid = 1'b0; tick();
        check("drop_vld",  {31'b0, ext_valid}, 32'h0);
        check("drop_q",    ext_q,             32'h0000_1234);
        check("drop_zero", {31'b0, ext_zero},  32'h0);

        // Zero result sets the zero flag.
        sign_extend_in = 16'h0000; ext_mode = 2'b01; in_valid = 1'b1; tick();
        check("zero_q",    ext_q,             32'h0);
        check("zero_flag", {31'b0, ext_zero},  32'h1);
        check("zero_vld",  {31'b0, ext_valid}, 32'h1);
        check("zero_neg",  {31'b0, ext_neg},   32'h0);

        // Load a negative value, then reset mid-stream with stall and valid high.
        sign_extend_in = 16'h8001; ext_mode = 2'b00; tick();
        check("pre_rst_neg", {31'b0, ext_neg}, 32'h1);
        rst = 1'b1; stall = 1'b1; in_valid = 1'b1; sign_extend_in = 16'hABCD; tick();
        check("mid_rst_q",    ext_q,             32'h0);
        check("mid_rst_vld",  {31'b0, ext_valid}, 32'h0);
        check("mid_rst_neg",  {31'b0, ext_neg},   32'h0);
        check("mid_rst_zero", {31'b0, ext_zero},  32'h1);
        check("mid_rst_dout", data_out,          32'hFFFF_ABCD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
